// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared AS2650 multiply definitions: state encodings, opcode, default sizes
package mul_seq_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam logic [7:0] MUL_OPCODE        = 8'h90;
  localparam int         MUL_WIDTH_DEFAULT = 8;
  localparam int         MUL_CNT_W_DEFAULT = 4;

endpackage

// File: rtl/mul_seq_dp.sv
// rtl/mul_seq_dp.sv - shift-add multiply datapath (acc/mcand/mplier); MUL_EARLY_EXIT_EN adds mplier_zero
module mul_seq_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               clear,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef MUL_EARLY_EXIT_EN
  output logic               mplier_zero,
`endif
  output logic [2*WIDTH-1:0] acc_step
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Accumulator value after the current iteration; the FSM captures it on DONE entry.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MUL_EARLY_EXIT_EN
  assign mplier_zero = ((mplier_q >> 1) == '0);
`endif

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
    end else if (clear) begin
      acc_d    = '0;
      mplier_d = '0;
    end else if (step) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - AS2650 MUL sequencer: FSM, iteration counter, result/flag registers; MUL_EARLY_EXIT_EN enables early exit
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT,
  parameter int CNT_W = MUL_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             zero,
  output logic             ovf
);

  ms_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, zero_q, ovf_q;
  logic [WIDTH-1:0]   prod_lo_q, prod_hi_q;
  logic [2*WIDTH-1:0] acc_step;
  logic               in_run, in_idle, dp_load, dp_step, last_iter;

  // Encoding 2'd3 falls through to the IDLE behaviour everywhere.
  assign in_run  = (state_q == MS_RUN);
  assign in_idle = (state_q != MS_RUN) && (state_q != MS_DONE);
  assign dp_load = in_idle && start && !abort;
  assign dp_step = in_run && !abort;

`ifdef MUL_EARLY_EXIT_EN
  logic mplier_zero;
  assign last_iter = (cnt_q <= CNT_W'(1)) || mplier_zero;
`else
  assign last_iter = (cnt_q <= CNT_W'(1));
`endif

  mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (dp_load),
    .step       (dp_step),
    .clear      (abort),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef MUL_EARLY_EXIT_EN
    .mplier_zero(mplier_zero),
`endif
    .acc_step   (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MS_RUN: begin
          if (abort) begin
            state_q <= MS_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter) begin
              state_q   <= MS_DONE;
              done_q    <= 1'b1;
              prod_lo_q <= acc_step[WIDTH-1:0];
              prod_hi_q <= acc_step[2*WIDTH-1:WIDTH];
              zero_q    <= (acc_step == '0);
              ovf_q     <= (acc_step[2*WIDTH-1:WIDTH] != '0);
            end
          end
        end
        MS_DONE: begin
          state_q <= MS_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= MS_IDLE;
          if (start && !abort) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH);
`ifdef MUL_EARLY_EXIT_EN
            if (op_b == '0) begin
              state_q   <= MS_DONE;
              done_q    <= 1'b1;
              prod_lo_q <= '0;
              prod_hi_q <= '0;
              zero_q    <= 1'b1;
              ovf_q     <= 1'b0;
            end else begin
              state_q <= MS_RUN;
            end
`else
            state_q <= MS_RUN;
`endif
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_lo = prod_lo_q;
  assign prod_hi = prod_hi_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq
module tb_mul_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] op_a, op_b, prod_lo, prod_hi;
  logic       busy, done, zero, ovf;
  int         vectors = 0;
  int         miscompares = 0;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_lo(prod_lo), .prod_hi(prod_hi), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Edges from the sampling edge (edge 1) to the edge after which done is seen.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hb;
    if (b == 8'd0) return 1;
    hb = 0;
    for (int i = 0; i < 8; i++) if (b[i]) hb = i;
    return hb + 2;
`else
    return 9;
`endif
  endfunction

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, output int lat, output logic [15:0] p);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = {prod_hi, prod_lo};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_a = 8'd0; op_b = 8'd0;
    #12;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if ({prod_hi, prod_lo} !== 16'h0000) begin miscompares++; $display("FAIL reset_prod got=%h exp=0000", {prod_hi, prod_lo}); end
    vectors++; if (zero !== 1'b1 || ovf !== 1'b0) begin miscompares++; $display("FAIL reset_flags got zero=%b ovf=%b exp zero=1 ovf=0", zero, ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] p;
    run_mul(8'd50, 8'd10, lat, p);
    vectors++; if (lat !== exp_lat(8'd10)) begin miscompares++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(8'd10)); end
    vectors++; if (p !== 16'h01F4) begin miscompares++; $display("FAIL basic_prod got=%h exp=01f4", p); end
    vectors++; if (ovf !== 1'b1 || zero !== 1'b0) begin miscompares++; $display("FAIL basic_flags got ovf=%b zero=%b exp ovf=1 zero=0", ovf, zero); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [15:0] p;
    op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrun_reset_ctl got busy=%b done=%b exp 0 0", busy, done); end
    vectors++; if ({prod_hi, prod_lo} !== 16'h0000 || zero !== 1'b1 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL midrun_reset_result got prod=%h zero=%b ovf=%b exp 0000 1 0", {prod_hi, prod_lo}, zero, ovf);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(8'd50, 8'd10, lat, p);
    vectors++; if (p !== 16'h01F4 || lat !== exp_lat(8'd10)) begin miscompares++; $display("FAIL post_reset_mul got prod=%h lat=%0d exp 01f4 %0d", p, lat, exp_lat(8'd10)); end
  endtask

  task automatic test_corners();
    logic [7:0]  ta [3] = '{8'hFF, 8'h00, 8'h0F};
    logic [7:0]  tb [3] = '{8'hFF, 8'h37, 8'h01};
    logic [15:0] tp [3] = '{16'hFE01, 16'h0000, 16'h000F};
    logic        tz [3] = '{1'b0, 1'b1, 1'b0};
    logic        to [3] = '{1'b1, 1'b0, 1'b0};
    int lat; logic [15:0] p;
    for (int i = 0; i < 3; i++) begin
      run_mul(ta[i], tb[i], lat, p);
      vectors++; if (p !== tp[i]) begin miscompares++; $display("FAIL corner_prod[%0d] got=%h exp=%h", i, p, tp[i]); end
      vectors++; if (zero !== tz[i] || ovf !== to[i]) begin miscompares++; $display("FAIL corner_flags[%0d] got zero=%b ovf=%b exp %b %b", i, zero, ovf, tz[i], to[i]); end
      vectors++; if (lat !== exp_lat(tb[i])) begin miscompares++; $display("FAIL corner_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(tb[i])); end
    end
  endtask

  task automatic test_back_to_back();
    int npulse = 0, first = -1, second = -1, stable_bad = 0, l;
    logic [15:0] held = 16'hxxxx;
    logic busy10 = 1'bx;
    l = exp_lat(8'd4);
    op_a = 8'd3; op_b = 8'd4; start = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (npulse == 1) begin first = e; held = {prod_hi, prod_lo}; end
        else second = e;
      end else if (npulse == 1 && {prod_hi, prod_lo} !== held) begin
        stable_bad++;
      end
      if (e == l + 1) busy10 = busy;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (npulse !== 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=2", npulse); end
    vectors++; if (first !== l) begin miscompares++; $display("FAIL b2b_first_done got=%0d exp=%0d", first, l); end
    vectors++; if (second !== 2 * l + 1) begin miscompares++; $display("FAIL b2b_second_done got=%0d exp=%0d", second, 2 * l + 1); end
    vectors++; if (held !== 16'h000C || {prod_hi, prod_lo} !== 16'h000C) begin miscompares++; $display("FAIL b2b_prod got first=%h second=%h exp 000c", held, {prod_hi, prod_lo}); end
    vectors++; if (stable_bad !== 0) begin miscompares++; $display("FAIL b2b_stable got=%0d changes exp=0", stable_bad); end
    vectors++; if (busy10 !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_gap got=%b exp=0", busy10); end
  endtask

  task automatic test_abort();
    int ndone = 0, lat; logic [15:0] p;
    op_a = 8'd7; op_b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", busy); end
    for (int e = 0; e < 12; e++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d pulses exp=0", ndone); end
    vectors++; if ({prod_hi, prod_lo} !== 16'h000C || zero !== 1'b0 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL abort_held got prod=%h zero=%b ovf=%b exp 000c 0 0", {prod_hi, prod_lo}, zero, ovf);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_idle got busy=%b exp=0", busy); end
    run_mul(8'd7, 8'd9, lat, p);
    vectors++; if (p !== 16'h003F || lat !== exp_lat(8'd9)) begin miscompares++; $display("FAIL abort_rerun got prod=%h lat=%0d exp 003f %0d", p, lat, exp_lat(8'd9)); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] p, exp_p; logic [7:0] a, b;
    for (int i = 0; i < 32; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_p = 16'(a) * 16'(b);
      run_mul(a, b, lat, p);
      vectors++; if (p !== exp_p) begin miscompares++; $display("FAIL rand_prod %h*%h got=%h exp=%h", a, b, p, exp_p); end
      vectors++; if (lat !== exp_lat(b)) begin miscompares++; $display("FAIL rand_latency %h*%h got=%0d exp=%0d", a, b, lat, exp_lat(b)); end
      vectors++; if (zero !== (exp_p == 16'h0) || ovf !== (exp_p[15:8] != 8'h0)) begin
        miscompares++; $display("FAIL rand_flags %h*%h got zero=%b ovf=%b", a, b, zero, ovf);
      end
    end
  endtask

  task automatic test_early_exit();
`ifdef MUL_EARLY_EXIT_EN
    int lat; logic [15:0] p;
    run_mul(8'd77, 8'd1, lat, p);
    vectors++; if (lat !== 2 || p !== 16'h004D) begin miscompares++; $display("FAIL early_b1 got lat=%0d prod=%h exp 2 004d", lat, p); end
    run_mul(8'd77, 8'd0, lat, p);
    vectors++; if (lat !== 1 || p !== 16'h0000 || zero !== 1'b1) begin miscompares++; $display("FAIL early_b0 got lat=%0d prod=%h zero=%b exp 1 0000 1", lat, p, zero); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_corners();
    test_back_to_back();
    test_abort();
    test_random();
    test_early_exit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
